// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-channel PWM with a decaying afterglow for the LED chaser.
// A lit channel snaps to full brightness and fades out in fixed steps once it
// goes dark. Bypass mode passes the (registered) pattern straight through.
module led_pwm_fader #(
  parameter int CH         = 6,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 270000,
  parameter int DECAY_STEP = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [CH-1:0] pat_in,
  input  logic          fade_en,
  output logic [CH-1:0] led_out,
  output logic          pwm_sync
);

  localparam int                  DIV_W    = $clog2(DECAY_DIV);
  localparam logic [PWM_BITS-1:0] LMAX     = '1;
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);

  logic [CH-1:0]       pat_q_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic                decay_tick;
  logic [CH-1:0]       lit;

  // Input stage: the pattern is only ever used through this register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pat_q_reg <= '1;
    end else begin
      pat_q_reg <= pat_in;
    end
  end

  // Free-running PWM counter; wraps naturally at LMAX.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_ONE;
    end
  end

  // Decay prescaler: counts 0..DECAY_DIV-1, independent of inputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_ONE;
    end
  end

  assign decay_tick = (div_cnt_reg == DIV_LAST);

  // Per-channel brightness level and PWM compare.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [PWM_BITS-1:0] lvl_reg;
    logic [PWM_BITS-1:0] lvl_next;

    // Relight beats decay; decay saturates at zero instead of wrapping.
    always_comb begin
      lvl_next = lvl_reg;
      if (!pat_q_reg[gi]) begin
        lvl_next = LMAX;
      end else if (decay_tick) begin
        lvl_next = (lvl_reg > STEP) ? (lvl_reg - STEP) : '0;
      end
    end

    // Level register keeps tracking even while in bypass mode.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        lvl_reg <= '0;
      end else begin
        lvl_reg <= lvl_next;
      end
    end

    // Full level forces solid on so LMAX is a true 100% duty.
    assign lit[gi] = (lvl_reg == LMAX) | (lvl_reg > pwm_cnt_reg);
  end

  // Registered outputs: PWM'd levels or the raw pattern, plus period marker.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_out  <= '1;
      pwm_sync <= 1'b0;
    end else begin
      led_out  <= fade_en ? ~lit : pat_q_reg;
      pwm_sync <= (pwm_cnt_reg == LMAX);
    end
  end

endmodule
